// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared state encoding and default sizing for mem_port_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEFAULT_AW          = 32;
    localparam int DEFAULT_DW          = 32;
    localparam int DEFAULT_MAX_D_BURST = 4;
    localparam int DEFAULT_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_wdog.sv
// ============================================================================
// Module : mem_arb_wdog
// Brief  : Busy-cycle watchdog; load clears, expire flags the last allowed cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int W     = 16,
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] C_LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (en && !expire) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expire = en && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between fetch and load/store requesters.
//          Optional busy watchdog: define MEM_PORT_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = DEFAULT_AW,
    parameter int DW          = DEFAULT_DW,
    parameter int MAX_D_BURST = DEFAULT_MAX_D_BURST,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          stall,
    output logic          bus_err
);

    localparam int           BW    = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] C_MAX = BW'(MAX_D_BURST);

    state_t        r_state;
    logic [BW-1:0] r_burst;
    logic          w_if_live;
    logic          w_d_live;
    logic          w_idle_ok;
    logic          w_grant_if;
    logic          w_grant_d;
    logic          w_expire;

    assign w_if_live = if_req && !if_ack;
    assign w_d_live  = d_req && !d_ack;

    // No grant in an ack cycle: the finished requester still holds its req,
    // and the 3-cycle transaction rhythm keeps burst accounting predictable.
    assign w_idle_ok  = (r_state == ST_IDLE) && !(if_ack || d_ack);
    assign w_grant_if = w_idle_ok && w_if_live && ((r_burst == C_MAX) || !w_d_live);
    assign w_grant_d  = w_idle_ok && w_d_live && !w_grant_if;

    assign stall = w_if_live || w_d_live;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    mem_arb_wdog #(
        .W     (16),
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (w_grant_if || w_grant_d),
        .en     (r_state != ST_IDLE),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_burst  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= 4'h0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            if (!if_req) begin
                r_burst <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_if) begin
                        r_state <= ST_BUSY_IF;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_be    <= 4'hF;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        r_burst <= '0;
                    end else if (w_grant_d) begin
                        r_state <= ST_BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_be    <= d_be;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        if (if_req && (r_burst != C_MAX)) begin
                            r_burst <= r_burst + BW'(1);
                        end
                    end
                end
                ST_BUSY_IF: begin
                    if (m_ready || w_expire) begin
                        m_req    <= 1'b0;
                        if_rdata <= m_ready ? m_rdata : '0;
                        if_ack   <= 1'b1;
                        bus_err  <= !m_ready;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (m_ready || w_expire) begin
                        m_req <= 1'b0;
                        if (!m_ready) begin
                            d_rdata <= '0;
                        end else if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        d_ack   <= 1'b1;
                        bus_err <= !m_ready;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Scoreboard bench: expected memory transactions and read data are
//          queued when requests are driven and popped as the DUT responds.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk, rst;
    logic        if_req, if_ack, d_req, d_we, d_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_be;
    logic        m_req, m_we, m_ready, stall, bus_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    txn_t        exp_txn[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic [31:0] last_d_rd;
    int          n_vec, n_err, cyc, mem_wait, last_run;
    logic        mem_dead, exp_err;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MAX_D_BURST(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .stall(stall), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory model: m_ready after mem_wait idle cycles of m_req
    initial begin
        int wcnt;
        wcnt = 0;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req && !mem_dead) begin
                if (wcnt == mem_wait) begin
                    m_ready = 1'b1;
                    m_rdata = mem_word(m_addr);
                    wcnt = 0;
                end else begin
                    m_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                m_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: grant order/content, stability, read data, ack width, stall
    initial begin
        txn_t        t;
        logic        p_mreq, p_if, p_d;
        logic [36:0] cap_hdr;
        logic [31:0] cap_wd, e;
        int          run;
        p_mreq = 1'b0; p_if = 1'b0; p_d = 1'b0; run = 0;
        cap_hdr = '0; cap_wd = '0;
        forever begin
            @(negedge clk);
            if (m_req && !p_mreq) begin
                if (exp_txn.size() == 0) begin
                    chk("grant_unexp", m_req, 1'b0);
                end else begin
                    t = exp_txn.pop_front();
                    chk("m_addr", m_addr, t.addr);
                    chk("m_we_be", {m_we, m_be}, {t.we, t.be});
                    if (t.we) chk("m_wdata", m_wdata, t.wdata);
                end
                cap_hdr = {m_we, m_be, m_addr};
                cap_wd  = m_wdata;
                run = 1;
            end else if (m_req) begin
                chk("m_stable", {m_we, m_be, m_addr}, cap_hdr);
                chk("m_wdata_stable", m_wdata, cap_wd);
                run++;
            end
            if (!m_req && p_mreq) last_run = run;
            if (if_ack) begin
                if (exp_if.size() == 0) begin
                    chk("if_ack_unexp", if_ack, 1'b0);
                end else begin
                    e = exp_if.pop_front();
                    chk("if_rdata", if_rdata, e);
                end
                if (p_if) chk("if_ack_width", p_if, 1'b0);
            end
            if (d_ack) begin
                if (exp_d.size() == 0) begin
                    chk("d_ack_unexp", d_ack, 1'b0);
                end else begin
                    e = exp_d.pop_front();
                    chk("d_rdata", d_rdata, e);
                end
                if (p_d) chk("d_ack_width", p_d, 1'b0);
            end
            if (if_ack || d_ack) chk("bus_err", bus_err, exp_err);
            else if (bus_err) chk("bus_err_stray", bus_err, 1'b0);
            chk("stall", stall, (if_req && !if_ack) || (d_req && !d_ack));
            p_mreq = m_req; p_if = if_ack; p_d = d_ack;
        end
    end

    task automatic push_f(input logic [31:0] addr);
        exp_txn.push_back('{we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0});
        exp_if.push_back(mem_word(addr));
    endtask

    task automatic push_d(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        exp_txn.push_back('{we: we, be: be, addr: addr, wdata: wdata});
        if (!we) last_d_rd = mem_word(addr);
        exp_d.push_back(last_d_rd);
    endtask

    task automatic run_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit early_drop);
        int n;
        d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        if (early_drop) begin
            @(posedge clk);
            #1;
            d_req = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 300);
        chk("d_ack_seen", d_ack, 1'b1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic run_f(input logic [31:0] addr, output int lat);
        int n, start;
        if_addr = addr; if_req = 1'b1;
        start = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ack && n < 300);
        chk("if_ack_seen", if_ack, 1'b1);
        lat = cyc - start;
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    initial begin
        int lat, n;
        n_vec = 0; n_err = 0; mem_wait = 0; mem_dead = 1'b0; exp_err = 1'b0;
        last_d_rd = '0; last_run = 0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_acks", {if_ack, d_ack, bus_err}, 3'b000);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_m_addr_be", {m_be, m_addr}, 36'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single fetch, latency 2
        push_f(32'h100);
        run_f(32'h100, lat);
        chk("if_latency", lat, 2);

        // Load then store; store leaves d_rdata alone
        push_d(1'b0, 4'hF, 32'h2000, 32'h0);
        run_d(1'b0, 4'hF, 32'h2000, 32'h0, 1'b0);
        push_d(1'b1, 4'b0011, 32'h2004, 32'h0000ABCD);
        run_d(1'b1, 4'b0011, 32'h2004, 32'h0000ABCD, 1'b0);

        // Conflict: 4 data grants, then one fetch, repeating
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) push_d(1'b0, 4'hF, 32'h2200 + 32'(16 * k + 4 * i), 32'h0);
            push_f(32'h1000 + 32'(4 * k));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) run_d(1'b0, 4'hF, 32'h2200 + 32'(4 * i), 32'h0, 1'b0);
            end
            begin
                int fl;
                for (int j = 0; j < 2; j++) run_f(32'h1000 + 32'(4 * j), fl);
            end
        join

        // Wait states: req stays high through the ack cycle, no re-grant
        mem_wait = 5;
        push_d(1'b0, 4'hF, 32'h2100, 32'h0);
        run_d(1'b0, 4'hF, 32'h2100, 32'h0, 1'b0);
        chk("wait_mreq_len", last_run, 6);
        push_f(32'h1040);
        run_f(32'h1040, lat);
        chk("wait_if_latency", lat, 7);
        mem_wait = 0;

        // Request dropped early still completes
        push_d(1'b0, 4'hF, 32'h2300, 32'h0);
        run_d(1'b0, 4'hF, 32'h2300, 32'h0, 1'b1);

        // Reset mid-transaction
        mem_wait = 12;
        exp_txn.push_back('{we: 1'b0, be: 4'hF, addr: 32'h3000, wdata: 32'h0});
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3000; d_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req && n < 20);
        chk("rst_mid_busy", m_req, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_mreq", m_req, 1'b0);
        d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ack", d_ack, 1'b0);
        end
        chk("rst_mid_d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_wait = 0;
        last_d_rd = '0;
        push_d(1'b0, 4'hF, 32'h3008, 32'h0);
        run_d(1'b0, 4'hF, 32'h3008, 32'h0, 1'b0);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
        // Watchdog: no m_ready, abort after 8 busy cycles
        mem_dead = 1'b1;
        exp_err = 1'b1;
        exp_txn.push_back('{we: 1'b0, be: 4'hF, addr: 32'h4000, wdata: 32'h0});
        last_d_rd = '0;
        exp_d.push_back(32'h0);
        run_d(1'b0, 4'hF, 32'h4000, 32'h0, 1'b0);
        chk("tmo_len", last_run, 8);
        mem_dead = 1'b0;
        exp_err = 1'b0;
        push_d(1'b0, 4'hF, 32'h4004, 32'h0);
        run_d(1'b0, 4'hF, 32'h4004, 32'h0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("txn_left", exp_txn.size(), 0);
        chk("if_left", exp_if.size(), 0);
        chk("d_left", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
